// File: rtl/enigma_pkg.sv
// Shared constants for the three-rotor scrambler: letters, rotor/reflector wirings,
// notch positions, FSM encoding and small mod-26 helpers.
package enigma_pkg;

   typedef logic [4:0] ltr_t;

   localparam ltr_t A = 5'd0,  B = 5'd1,  C = 5'd2,  D = 5'd3,  E = 5'd4,  F = 5'd5;
   localparam ltr_t G = 5'd6,  H = 5'd7,  I = 5'd8,  J = 5'd9,  K = 5'd10, L = 5'd11;
   localparam ltr_t M = 5'd12, N = 5'd13, O = 5'd14, P = 5'd15, Q = 5'd16, R = 5'd17;
   localparam ltr_t S = 5'd18, T = 5'd19, U = 5'd20, V = 5'd21, W = 5'd22, X = 5'd23;
   localparam ltr_t Y = 5'd24, Z = 5'd25;

   localparam int ROTOR_I = 0, ROTOR_II = 1, ROTOR_III = 2;

   localparam ltr_t ROT_I_F   [26] = '{4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9};
   localparam ltr_t ROT_I_R   [26] = '{20,22,24,6,0,3,5,15,21,25,1,4,2,10,12,19,7,23,18,11,17,8,13,16,14,9};
   localparam ltr_t ROT_II_F  [26] = '{0,9,3,10,18,8,17,20,23,1,11,7,22,19,12,2,16,6,25,13,15,24,5,21,14,4};
   localparam ltr_t ROT_II_R  [26] = '{0,9,15,2,25,22,17,11,5,1,3,10,14,19,24,20,16,6,4,13,7,23,12,8,21,18};
   localparam ltr_t ROT_III_F [26] = '{1,3,5,7,9,11,2,15,17,19,23,21,25,13,24,4,8,22,6,0,10,12,14,20,18,16};
   localparam ltr_t ROT_III_R [26] = '{19,0,6,1,15,2,18,3,16,4,20,5,21,13,22,7,25,8,24,9,23,11,17,10,14,12};
   localparam ltr_t REFL_B    [26] = '{24,17,20,7,16,18,11,3,15,23,13,6,14,10,12,8,4,1,5,25,2,22,21,9,0,19};

   localparam ltr_t NOTCH_I = 5'd16, NOTCH_II = 5'd4, NOTCH_III = 5'd21;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_STEP = 2'd1, ST_ENC = 2'd2} state_e;

   function automatic ltr_t refl_b(input ltr_t x);
      return REFL_B[x];
   endfunction

   function automatic ltr_t mod26(input ltr_t v);
      return (v > 5'd25) ? 5'(v - 5'd26) : v;
   endfunction

   // (a - b) mod 26 for a,b in 0..25, kept non-negative by adding 26 first
   function automatic ltr_t sub_mod26(input ltr_t a, input ltr_t b);
      logic [5:0] t;
      t = {1'b0, a} + 6'd26 - {1'b0, b};
      return (t >= 6'd26) ? 5'(t - 6'd26) : t[4:0];
   endfunction

   function automatic ltr_t inc26(input ltr_t v);
      return (v == 5'd25) ? 5'd0 : 5'(v + 5'd1);
   endfunction

endpackage

// File: rtl/enigma_rotor_map.sv
// One rotor pass: y = (W[(x+off) mod 26] - off) mod 26, W or its inverse chosen by dir.
module enigma_rotor_map
   import enigma_pkg::*;
#(
   parameter int ROTOR = ROTOR_I
) (
   input  logic [4:0] x_i,
   input  logic [4:0] off_i,
   input  logic       dir_i,
   output logic [4:0] y_o
);

   logic [5:0] sum;
   logic [4:0] idx;
   logic [4:0] w;

   always_comb begin
      sum = {1'b0, x_i} + {1'b0, off_i};
      idx = (sum >= 6'd26) ? 5'(sum - 6'd26) : sum[4:0];
      w   = '0;
      case (ROTOR)
         ROTOR_I:   w = dir_i ? ROT_I_R[idx]   : ROT_I_F[idx];
         ROTOR_II:  w = dir_i ? ROT_II_R[idx]  : ROT_II_F[idx];
         default:   w = dir_i ? ROT_III_R[idx] : ROT_III_F[idx];
      endcase
      y_o = sub_mod26(w, off_i);
   end

endmodule

// File: rtl/enigma_rotor_bank.sv
// Three-rotor scrambler (I/II/III, reflector B): step on accept, then encode with
// the post-step positions; one letter per three cycles.
module enigma_rotor_bank
   import enigma_pkg::*;
#(
   parameter int RING_L = 0,
   parameter int RING_M = 0,
   parameter int RING_R = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   input  logic       load_en,
   input  logic [4:0] pos_l_in,
   input  logic [4:0] pos_m_in,
   input  logic [4:0] pos_r_in,
   output logic [4:0] char_out,
   output logic       out_valid,
   output logic       bad_char,
   output logic [4:0] pos_l,
   output logic [4:0] pos_m,
   output logic [4:0] pos_r
);

   localparam logic [4:0] RL = 5'(RING_L);
   localparam logic [4:0] RM = 5'(RING_M);
   localparam logic [4:0] RR = 5'(RING_R);

   state_e     state_q;
   logic [4:0] pos_l_q, pos_m_q, pos_r_q;
   logic [4:0] pos_l_d, pos_m_d, pos_r_d;
   logic [4:0] char_q, char_out_q;
   logic       out_valid_q, bad_char_q;

   logic       bad;
   logic [4:0] off_l, off_m, off_r;
   logic [4:0] r_f, m_f, l_f, refl, l_r, m_r, r_r;

   assign bad        = (char_q > 5'd25);
   assign char_ready = (state_q == ST_IDLE) & ~load_en;

   // Middle rotor sees its own notch as well as the right one (double step)
   always_comb begin
      pos_r_d = inc26(pos_r_q);
      pos_m_d = pos_m_q;
      pos_l_d = pos_l_q;
      if (pos_r_q == NOTCH_III || pos_m_q == NOTCH_II) pos_m_d = inc26(pos_m_q);
      if (pos_m_q == NOTCH_II) pos_l_d = inc26(pos_l_q);
   end

   assign off_l = sub_mod26(pos_l_q, RL);
   assign off_m = sub_mod26(pos_m_q, RM);
   assign off_r = sub_mod26(pos_r_q, RR);

   enigma_rotor_map #(.ROTOR(ROTOR_III)) u_r_f (.x_i(char_q), .off_i(off_r), .dir_i(1'b0), .y_o(r_f));
   enigma_rotor_map #(.ROTOR(ROTOR_II))  u_m_f (.x_i(r_f),    .off_i(off_m), .dir_i(1'b0), .y_o(m_f));
   enigma_rotor_map #(.ROTOR(ROTOR_I))   u_l_f (.x_i(m_f),    .off_i(off_l), .dir_i(1'b0), .y_o(l_f));
   assign refl = refl_b(l_f);
   enigma_rotor_map #(.ROTOR(ROTOR_I))   u_l_r (.x_i(refl),   .off_i(off_l), .dir_i(1'b1), .y_o(l_r));
   enigma_rotor_map #(.ROTOR(ROTOR_II))  u_m_r (.x_i(l_r),    .off_i(off_m), .dir_i(1'b1), .y_o(m_r));
   enigma_rotor_map #(.ROTOR(ROTOR_III)) u_r_r (.x_i(m_r),    .off_i(off_r), .dir_i(1'b1), .y_o(r_r));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pos_l_q     <= '0;
         pos_m_q     <= '0;
         pos_r_q     <= '0;
         char_q      <= '0;
         char_out_q  <= '0;
         out_valid_q <= 1'b0;
         bad_char_q  <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (load_en) begin
                  pos_l_q <= mod26(pos_l_in);
                  pos_m_q <= mod26(pos_m_in);
                  pos_r_q <= mod26(pos_r_in);
               end else if (char_valid) begin
                  char_q  <= char_in;
                  state_q <= ST_STEP;
               end
            end
            ST_STEP: begin
               if (!bad) begin
                  pos_l_q <= pos_l_d;
                  pos_m_q <= pos_m_d;
                  pos_r_q <= pos_r_d;
               end
               state_q <= ST_ENC;
            end
            ST_ENC: begin
               char_out_q  <= bad ? char_q : r_r;
               bad_char_q  <= bad;
               out_valid_q <= 1'b1;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign char_out  = char_out_q;
   assign out_valid = out_valid_q;
   assign bad_char  = bad_char_q;
   assign pos_l     = pos_l_q;
   assign pos_m     = pos_m_q;
   assign pos_r     = pos_r_q;

endmodule

// File: tb/tb_enigma_rotor_bank.sv
// Directed bench for enigma_rotor_bank against hand-worked Enigma I/II/III + UKW-B vectors.
module tb_enigma_rotor_bank;
   import enigma_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] char_in = '0;
   logic       char_valid = 1'b0;
   logic       char_ready;
   logic       load_en = 1'b0;
   logic [4:0] pos_l_in = '0, pos_m_in = '0, pos_r_in = '0;
   logic [4:0] char_out;
   logic       out_valid, bad_char;
   logic [4:0] pos_l, pos_m, pos_r;

   int n_checks = 0;
   int n_fail   = 0;

   enigma_rotor_bank dut (
      .clk(clk), .rst_n(rst_n),
      .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
      .load_en(load_en), .pos_l_in(pos_l_in), .pos_m_in(pos_m_in), .pos_r_in(pos_r_in),
      .char_out(char_out), .out_valid(out_valid), .bad_char(bad_char),
      .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_pos(input string tag, input int l, input int m, input int r);
      chk(tag, int'({pos_l, pos_m, pos_r}), (l << 10) | (m << 5) | r);
   endtask

   task automatic load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
      load_en = 1'b1; pos_l_in = l; pos_m_in = m; pos_r_in = r;
      @(posedge clk); #1;
      load_en = 1'b0;
   endtask

   // Enters and leaves at posedge+1; checks the accept-to-out_valid latency.
   task automatic send(input logic [4:0] c, output logic [4:0] oc, output logic ob);
      int  n, lat;
      n = 0;
      while (!char_ready && n < 10) begin @(posedge clk); #1; n++; end
      char_in = c; char_valid = 1'b1;
      @(posedge clk); #1;
      char_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 8 && lat == 0; k++) begin
         @(negedge clk);
         if (out_valid) lat = k;
      end
      chk("latency", lat, 3);
      oc = char_out; ob = bad_char;
      @(posedge clk); #1;
   endtask

   logic [4:0] oc;
   logic       ob, any_bad;
   logic [4:0] pt [5], ct [5], got_ct [5];
   logic [8:0] rdy_pat, ov_pat;
   int         ov_cnt;

   initial begin
      pt = '{H, E, L, L, O};
      ct = '{D, M, B, K, B};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_bad_char", bad_char, 0);
      chk("rst_char_out", char_out, 0);
      chk("rst_ready", char_ready, 0 + 1);
      chk_pos("rst_pos", 0, 0, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // AAAAA from AAA -> BDZGO
      begin
         logic [4:0] exp_a [5];
         exp_a = '{B, D, Z, G, O};
         for (int k = 0; k < 5; k++) begin
            send(A, oc, ob);
            chk($sformatf("aaa_char%0d", k), oc, exp_a[k]);
         end
      end
      chk_pos("aaa_final_pos", 0, 0, 5);

      // double step from ADU
      load(A, D, U);
      chk_pos("load_adu", 0, 3, 20);
      send(A, oc, ob); chk_pos("dbl_step1", 0, 3, 21);
      send(A, oc, ob); chk_pos("dbl_step2", 0, 4, 22);
      send(A, oc, ob); chk_pos("dbl_step3", 1, 5, 23);

      // wrap
      load(Z, Z, Z);
      send(A, oc, ob); chk_pos("wrap_zzz", 25, 25, 0);
      load(Z, E, Z);
      send(A, oc, ob); chk_pos("wrap_zez", 0, 5, 0);

      // out-of-range load values are taken mod 26
      load(5'd31, 5'd26, 5'd27);
      chk_pos("load_mod26", 5, 0, 1);

      // reciprocity from MCK
      load(M, C, K);
      any_bad = 1'b0;
      for (int k = 0; k < 5; k++) begin
         send(pt[k], oc, ob);
         got_ct[k] = oc; any_bad |= ob;
         chk($sformatf("hello_enc%0d", k), oc, ct[k]);
      end
      chk_pos("hello_pos", 12, 2, 15);
      load(M, C, K);
      for (int k = 0; k < 5; k++) begin
         send(got_ct[k], oc, ob);
         any_bad |= ob;
         chk($sformatf("hello_dec%0d", k), oc, pt[k]);
      end
      chk("hello_bad_char", any_bad, 0);

      // char_valid held high: accept every third cycle
      char_in = A; char_valid = 1'b1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         rdy_pat[k] = char_ready;
         ov_pat[k]  = out_valid;
      end
      char_valid = 1'b0;
      chk("hold_ready_pattern", rdy_pat, 9'b001001001);
      chk("hold_valid_pattern", ov_pat, 9'b001001000);
      @(posedge clk); #1;
      @(posedge clk); #1;

      // load and char_valid together: load only
      char_in = A; char_valid = 1'b1;
      load_en = 1'b1; pos_l_in = B; pos_m_in = C; pos_r_in = D;
      #1;
      chk("load_blocks_ready", char_ready, 0);
      @(posedge clk); #1;
      load_en = 1'b0; char_valid = 1'b0;
      ov_cnt = 0;
      for (int k = 0; k < 5; k++) begin @(negedge clk); if (out_valid) ov_cnt++; end
      chk("load_wins_no_out", ov_cnt, 0);
      chk_pos("load_wins_pos", 1, 2, 3);
      @(posedge clk); #1;

      // bad character passes through, rotors hold
      send(5'd27, oc, ob);
      chk("bad_char_out", oc, 27);
      chk("bad_char_flag", ob, 1);
      chk_pos("bad_char_pos", 1, 2, 3);

      // reset during STEP aborts the letter
      char_in = A; char_valid = 1'b1;
      @(posedge clk); #1;
      char_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk_pos("abort_pos", 0, 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ov_cnt = 0;
      for (int k = 0; k < 5; k++) begin @(negedge clk); if (out_valid) ov_cnt++; end
      chk("abort_no_out", ov_cnt, 0);
      chk("abort_ready", char_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
